uart_tx_fifo: RTL

//  Next-generation UART transmitter: parametrised data width, built-in baud

---
 rtl/uart_tx_fifo_if.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo.
// Purpose: groups the host write handshake, per-word frame config and the
//          transmitter status/line outputs into one interface.
// Signals:
//   Data_valid  host write strobe
//   P_data      word to send (DATA_WIDTH bits)
//   Par_en      1 = append a parity bit
//   Par_type    0 = even parity, 1 = odd parity
//   Stop2       1 = two stop bits, 0 = one
//   Ready       FIFO can accept a word
//   Busy        a frame is on the line
//   TX_out      serial line, idle high
//   Fifo_count  words queued (0..FIFO_DEPTH)
// Modports: master = host side, slave = transmitter side.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  Data_valid;
    logic [DATA_WIDTH-1:0] P_data;
    logic                  Par_en;
    logic                  Par_type;
    logic                  Stop2;
    logic                  Ready;
    logic                  Busy;
    logic                  TX_out;
    logic [AW:0]           Fifo_count;

    modport master (
        output Data_valid, P_data, Par_en, Par_type, Stop2,
        input  Ready, Busy, TX_out, Fifo_count
    );

    modport slave (
        input  Data_valid, P_data, Par_en, Par_type, Stop2,
        output Ready, Busy, TX_out, Fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO and built-in baud divider.
// Purpose: queues host words together with their frame config (parity
//          enable/type, stop bits) and serialises them LSB-first as
//          start | data | [parity] | stop [stop]. Frames leave back-to-back
//          while the FIFO holds words.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active low
//   bus  uart_tx_fifo_if.slave: host handshake, config, status, TX_out
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 3;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push, pop, ready;

    logic [EW-1:0]         head_word;
    logic [DATA_WIDTH-1:0] head_data;

    // Ready looks only at the registered count, so a pop in the same cycle
    // never admits a push into a full FIFO.
    assign ready     = (count_reg != CW'(FIFO_DEPTH));
    assign push      = bus.Data_valid && ready;
    assign head_word = mem[rd_ptr_reg];
    assign head_data = head_word[EW-1:3];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.P_data, bus.Par_en, bus.Par_type, bus.Stop2};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- transmitter FSM ----------------
    state_t                state_reg, state_next;
    logic [BW-1:0]         baud_reg, baud_next;
    logic [NW-1:0]         bit_reg, bit_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  stop2_reg, stop2_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic                  bit_done, load;

    assign bit_done = (baud_reg == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            stop2_reg   <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            stop2_reg   <= stop2_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        stop2_next   = stop2_reg;
        load         = 1'b0;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (count_reg != '0) load = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == NW'(DATA_WIDTH - 1)) begin
                        bit_next   = '0;
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_next = bit_reg + NW'(1);
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_next = '0;
                    // bit_reg counts stop bits already sent in this state.
                    if (stop2_reg && bit_reg == '0) begin
                        bit_next = NW'(1);
                    end else if (count_reg != '0) begin
                        load = 1'b1;
                    end else begin
                        bit_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Pop the head word and latch its config; parity is resolved here
        // so later host activity cannot affect the frame.
        if (load) begin
            pop          = 1'b1;
            state_next   = START;
            baud_next    = '0;
            bit_next     = '0;
            shift_next   = head_data;
            par_en_next  = head_word[2];
            par_bit_next = head_word[1] ? ~^head_data : ^head_data;
            stop2_next   = head_word[0];
        end
    end

    // Outputs are decoded from the next state and registered, so TX_out
    // and Busy line up exactly with state_reg.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign bus.Ready      = ready;
    assign bus.Busy       = busy_reg;
    assign bus.TX_out     = tx_reg;
    assign bus.Fifo_count = count_reg;
endmodule
